ring_seq_ctrl: RTL and testbench
================================

RING_SEQ_CTRL -- requirements
Module: ring_seq_ctrl

Interface
REQ-001 SHALL provide parameter C_NUM_PHASES, default 8, giving the number of one-hot phases in the ring (legal range 2..64).
REQ-002 SHALL provide parameter C_LEN_W, default 3, giving the LEN width; it equals ceil(log2(C_NUM_PHASES)).
REQ-003 SHALL have port CK  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  in  1  run request; sampled only in IDLE.
REQ-006 SHALL have port STOP  in  1  request to end the run at the end of the current loop.
REQ-007 SHALL have port HOLD  in  1  freezes the phase while running.
REQ-008 SHALL have port LEN  in  C_LEN_W  index of the last active phase; sampled with START.
REQ-009 SHALL have port LOOPS  in  8  number of loops per run; 0 means run until STOP; sampled with START.
REQ-010 SHALL have port PHASE  out  C_NUM_PHASES  one-hot phase vector, registered.
REQ-011 SHALL have port BUSY  out  1  high while the state is RUN or STOPPING.
REQ-012 SHALL have port WRAP  out  1  one-cycle pulse on the first cycle of each new loop.
REQ-013 SHALL have port DONE  out  1  one-cycle pulse when the run ends.
REQ-014 SHALL have port ERR  out  1  sticky phase-integrity error flag.

Function
REQ-015 SHALL implement the states IDLE, RUN and STOPPING.
REQ-016 SHALL, on IDLE with START=1, move to RUN at that edge and latch len_q=min(LEN, C_NUM_PHASES-1) and loops_q=LOOPS; it also clears the loop count, sets PHASE=bit0 and sets BUSY=1 on the next cycle.
REQ-017 SHALL, in RUN or STOPPING with HOLD=0, advance PHASE one bit per cycle from bit0 up to bit len_q.
REQ-018 SHALL leave PHASE, the loop count and the state unchanged whenever HOLD=1; STOP is still latched while held.
REQ-019 SHALL, on advance from bit len_q, either return to bit0 with WRAP=1 and increment the loop count, or end the run.
REQ-020 SHALL end the run when the state is STOPPING, or when loops_q!=0 and the incremented loop count equals loops_q.
REQ-021 SHALL, on ending the run, go to IDLE with PHASE=0, BUSY=0 and DONE=1 for exactly one cycle; WRAP stays 0 on that cycle.
REQ-022 SHALL move RUN to STOPPING when STOP=1; the current loop still completes.
REQ-023 SHALL ignore STOP in IDLE and START outside IDLE.
REQ-024 SHALL, when START and STOP are both 1 in IDLE, start the run with STOP pending, so exactly one loop runs.
REQ-025 SHALL, with len_q=0, hold PHASE=bit0 and pulse WRAP every non-held cycle.
REQ-026 SHALL use an 8-bit loop count that wraps silently when LOOPS=0.

Reset
REQ-027 SHALL, with RST=1 at a clock edge, force IDLE with PHASE=0, BUSY=0, WRAP=0, DONE=0, ERR=0 and the count, len_q and loops_q cleared.
REQ-028 SHALL give RST priority over START, STOP and HOLD, and SHALL abort any run mid-loop without a DONE pulse.

Configuration
REQ-029 SHALL, when macro RING_SEQ_CTRL_ONEHOT_CHECK_EN is defined, set ERR on the cycle after PHASE violates its state: not exactly one bit set in RUN or STOPPING, or any bit set in IDLE.
REQ-030 SHALL keep ERR set until RST once it has been set.
REQ-031 SHALL, without RING_SEQ_CTRL_ONEHOT_CHECK_EN, tie ERR to 0 and remove the checker logic.

Verification
REQ-032 SHALL cover: N=8, LEN=3, LOOPS=2, START pulse -> PHASE 1,2,4,8,1,2,4,8; WRAP on the 5th cycle; DONE on the 9th; BUSY high for 8 cycles.
REQ-033 SHALL cover: LEN=7, LOOPS=0, STOP asserted while PHASE=bit2 -> PHASE continues to bit7, then DONE, with no WRAP.
REQ-034 SHALL cover: LEN=2, LOOPS=1, HOLD high for 3 cycles at bit1 -> bit1 is seen for 4 cycles; DONE arrives 3 cycles late.
REQ-035 SHALL cover: START and STOP together, LEN=1, LOOPS=0 -> PHASE 1,2, then DONE.
REQ-036 SHALL cover: RST while PHASE=bit4 -> next cycle PHASE=0, BUSY=0, no DONE.
REQ-037 SHALL cover, with the macro defined, forcing PHASE to 0x03 -> ERR=1 next cycle, held until RST.

Source files
------------

// File: rtl/ring_seq_ctrl.sv
// ring_seq_ctrl: one-hot ring phase sequencer.
// A run starts from IDLE on START, walks PHASE from bit0 up to bit len_q,
// wraps back to bit0 at the end of each loop and ends after LOOPS loops,
// or at the end of the loop in which STOP was seen. HOLD freezes the ring.
// Optional feature macro: RING_SEQ_CTRL_ONEHOT_CHECK_EN enables the sticky
// phase-integrity error flag ERR; without it ERR is tied low.
module ring_seq_ctrl #(
  parameter int C_NUM_PHASES = 8,
  parameter int C_LEN_W      = 3
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    HOLD,
  input  logic [C_LEN_W-1:0]      LEN,
  input  logic [7:0]              LOOPS,
  output logic [C_NUM_PHASES-1:0] PHASE,
  output logic                    BUSY,
  output logic                    WRAP,
  output logic                    DONE,
  output logic                    ERR
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [C_NUM_PHASES-1:0] PH_BIT0 = {{(C_NUM_PHASES-1){1'b0}}, 1'b1};
  localparam logic [C_NUM_PHASES-1:0] PH_NONE = {C_NUM_PHASES{1'b0}};
  localparam logic [C_LEN_W-1:0]      LEN_MAX = C_LEN_W'(C_NUM_PHASES - 1);
  localparam logic [C_LEN_W-1:0]      IDX_ONE = C_LEN_W'(1);

  state_t                    state_q, state_d;
  logic [C_NUM_PHASES-1:0]   phase_q, phase_d;
  logic [C_LEN_W-1:0]        idx_q, idx_d;
  logic [C_LEN_W-1:0]        len_q, len_d;
  logic [7:0]                loops_q, loops_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      wrap_q, wrap_d;
  logic                      done_q, done_d;
  logic [7:0]                cnt_inc_s;
  logic [C_LEN_W-1:0]        len_clamp_s;
  logic                      run_end_s;

  // Next-state, next-phase and pulse generation for the ring sequencer.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    len_d       = len_q;
    loops_d     = loops_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    cnt_inc_s   = cnt_q + 8'd1;
    len_clamp_s = (LEN > LEN_MAX) ? LEN_MAX : LEN;
    // The run ends at the last phase when stopping, or when a finite loop
    // budget is exhausted by the loop that is just completing.
    run_end_s   = (state_q == ST_STOPPING) ||
                  ((loops_q != 8'd0) && (cnt_inc_s == loops_q));

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          // START together with STOP runs exactly one loop.
          state_d = STOP ? ST_STOPPING : ST_RUN;
          phase_d = PH_BIT0;
          idx_d   = {C_LEN_W{1'b0}};
          cnt_d   = 8'd0;
          len_d   = len_clamp_s;
          loops_d = LOOPS;
        end else begin
          phase_d = PH_NONE;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (HOLD) begin
          // Ring frozen, but a stop request is still remembered.
          if (STOP) begin
            state_d = ST_STOPPING;
          end else begin
            state_d = state_q;
          end
        end else if (idx_q == len_q) begin
          if (run_end_s) begin
            state_d = ST_IDLE;
            phase_d = PH_NONE;
            idx_d   = {C_LEN_W{1'b0}};
            done_d  = 1'b1;
          end else begin
            state_d = STOP ? ST_STOPPING : state_q;
            phase_d = PH_BIT0;
            idx_d   = {C_LEN_W{1'b0}};
            cnt_d   = cnt_inc_s;
            wrap_d  = 1'b1;
          end
        end else begin
          state_d = STOP ? ST_STOPPING : state_q;
          phase_d = phase_q << 1;
          idx_d   = idx_q + IDX_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_NONE;
        idx_d   = {C_LEN_W{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered output update with synchronous reset.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      phase_q <= PH_NONE;
      idx_q   <= {C_LEN_W{1'b0}};
      len_q   <= {C_LEN_W{1'b0}};
      loops_q <= 8'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loops_q <= loops_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign PHASE = phase_q;
  assign BUSY  = busy_q;
  assign WRAP  = wrap_q;
  assign DONE  = done_q;

`ifdef RING_SEQ_CTRL_ONEHOT_CHECK_EN
  // True when exactly one bit of the vector is set.
  function automatic logic onehot_ok(input logic [C_NUM_PHASES-1:0] v);
    return (v != PH_NONE) && ((v & (v - PH_BIT0)) == PH_NONE);
  endfunction

  logic err_q;
  logic viol_s;

  // Phase-integrity check: one-hot while running, all-zero while idle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      viol_s = (phase_q != PH_NONE);
    end else begin
      viol_s = !onehot_ok(phase_q);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (viol_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Directed testbench for ring_seq_ctrl (N=8, LEN width 3).
module tb_ring_seq_ctrl;

  logic       CK;
  logic       RST;
  logic       START;
  logic       STOP;
  logic       HOLD;
  logic [2:0] LEN;
  logic [7:0] LOOPS;
  logic [7:0] PHASE;
  logic       BUSY;
  logic       WRAP;
  logic       DONE;
  logic       ERR;

  int tests;
  int fails;

  ring_seq_ctrl #(.C_NUM_PHASES(8), .C_LEN_W(3)) dut (
    .CK    (CK),
    .RST   (RST),
    .START (START),
    .STOP  (STOP),
    .HOLD  (HOLD),
    .LEN   (LEN),
    .LOOPS (LOOPS),
    .PHASE (PHASE),
    .BUSY  (BUSY),
    .WRAP  (WRAP),
    .DONE  (DONE),
    .ERR   (ERR)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (PHASE,BUSY,WRAP,DONE,ERR)", tag, obs, exp);
    end
  endtask

  // Clock once, then compare all outputs against the expected snapshot.
  task automatic step(input string tag, input logic [7:0] ph, input logic b,
                      input logic w, input logic d);
    tick();
    chk(tag, {PHASE, BUSY, WRAP, DONE, ERR}, {ph, b, w, d, 1'b0});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b1; START = 1'b0; STOP = 1'b0; HOLD = 1'b0;
    LEN = 3'd0; LOOPS = 8'd0;

    // Reset state, even with START/STOP/HOLD asserted.
    START = 1'b1; STOP = 1'b1; HOLD = 1'b1;
    step("reset0", 8'h00, 1'b0, 1'b0, 1'b0);
    START = 1'b0; STOP = 1'b0; HOLD = 1'b0;
    step("reset1", 8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    // STOP in IDLE is ignored.
    STOP = 1'b1;
    step("idle_stop", 8'h00, 1'b0, 1'b0, 1'b0);
    STOP = 1'b0;

    // LEN=3, LOOPS=2: 1,2,4,8,1(WRAP),2,4,8 then DONE.
    LEN = 3'd3; LOOPS = 8'd2; START = 1'b1;
    step("t1_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    step("t1_c2", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t1_c3", 8'h04, 1'b1, 1'b0, 1'b0);
    step("t1_c4", 8'h08, 1'b1, 1'b0, 1'b0);
    step("t1_c5", 8'h01, 1'b1, 1'b1, 1'b0);
    step("t1_c6", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t1_c7", 8'h04, 1'b1, 1'b0, 1'b0);
    step("t1_c8", 8'h08, 1'b1, 1'b0, 1'b0);
    step("t1_c9", 8'h00, 1'b0, 1'b0, 1'b1);
    step("t1_c10", 8'h00, 1'b0, 1'b0, 1'b0);

    // LEN=7, LOOPS=0, STOP at bit2: runs to bit7, DONE, no WRAP.
    LEN = 3'd7; LOOPS = 8'd0; START = 1'b1;
    step("t2_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    step("t2_c2", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t2_c3", 8'h04, 1'b1, 1'b0, 1'b0);
    STOP = 1'b1;
    step("t2_c4", 8'h08, 1'b1, 1'b0, 1'b0);
    STOP = 1'b0;
    step("t2_c5", 8'h10, 1'b1, 1'b0, 1'b0);
    step("t2_c6", 8'h20, 1'b1, 1'b0, 1'b0);
    step("t2_c7", 8'h40, 1'b1, 1'b0, 1'b0);
    step("t2_c8", 8'h80, 1'b1, 1'b0, 1'b0);
    step("t2_c9", 8'h00, 1'b0, 1'b0, 1'b1);

    // LEN=2, LOOPS=1, HOLD 3 cycles at bit1: bit1 for 4 cycles, DONE 3 late.
    LEN = 3'd2; LOOPS = 8'd1; START = 1'b1;
    step("t3_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    step("t3_c2", 8'h02, 1'b1, 1'b0, 1'b0);
    HOLD = 1'b1;
    step("t3_c3", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t3_c4", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t3_c5", 8'h02, 1'b1, 1'b0, 1'b0);
    HOLD = 1'b0;
    step("t3_c6", 8'h04, 1'b1, 1'b0, 1'b0);
    step("t3_c7", 8'h00, 1'b0, 1'b0, 1'b1);

    // START and STOP together, LEN=1, LOOPS=0: 1,2 then DONE.
    LEN = 3'd1; LOOPS = 8'd0; START = 1'b1; STOP = 1'b1;
    step("t4_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    START = 1'b0; STOP = 1'b0;
    step("t4_c2", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t4_c3", 8'h00, 1'b0, 1'b0, 1'b1);

    // LEN=0, LOOPS=3: bit0 held, WRAP each cycle, DONE after 3 loops.
    LEN = 3'd0; LOOPS = 8'd3; START = 1'b1;
    step("t5_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    step("t5_c2", 8'h01, 1'b1, 1'b1, 1'b0);
    step("t5_c3", 8'h01, 1'b1, 1'b1, 1'b0);
    step("t5_c4", 8'h00, 1'b0, 1'b0, 1'b1);

    // LEN=0, LOOPS=0 for 300 loops: count wraps silently, START ignored.
    LEN = 3'd0; LOOPS = 8'd0; START = 1'b1;
    step("t6_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    LEN = 3'd5; LOOPS = 8'd1;
    for (int i = 0; i < 300; i++) begin
      step("t6_run", 8'h01, 1'b1, 1'b1, 1'b0);
    end
    START = 1'b0; STOP = 1'b1;
    step("t6_stop", 8'h01, 1'b1, 1'b1, 1'b0);
    STOP = 1'b0;
    step("t6_done", 8'h00, 1'b0, 1'b0, 1'b1);

    // RST while PHASE=bit4: PHASE=0, BUSY=0, no DONE.
    LEN = 3'd7; LOOPS = 8'd0; START = 1'b1;
    step("t7_c1", 8'h01, 1'b1, 1'b0, 1'b0);
    START = 1'b0;
    step("t7_c2", 8'h02, 1'b1, 1'b0, 1'b0);
    step("t7_c3", 8'h04, 1'b1, 1'b0, 1'b0);
    step("t7_c4", 8'h08, 1'b1, 1'b0, 1'b0);
    step("t7_c5", 8'h10, 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    step("t7_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    step("t7_after", 8'h00, 1'b0, 1'b0, 1'b0);
    step("t7_after2", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef RING_SEQ_CTRL_ONEHOT_CHECK_EN
    // Corrupt PHASE to 0x03: ERR next cycle, sticky until RST.
    force dut.phase_q = 8'h03;
    tick();
    release dut.phase_q;
    chk("err_set", {11'd0, ERR}, 12'h001);
    tick();
    tick();
    chk("err_sticky", {11'd0, ERR}, 12'h001);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("err_clear", {11'd0, ERR}, 12'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
